ctrl_fsm_v2: RTL and testbench

Parametrised next-generation instruction control FSM for one distributed-processor core. It decodes the current instruction opcode and sequences the ALU, register file, instruction pointer, qclk and pulse strobe. It adds what the first-generation controller lacked: a real fproc request/response handshake, a sync barrier wait, a done/halt state, illegal-opcode and timeout error trapping, and fully defined outputs in every state.

---
 rtl/ctrl_fsm_v2.sv | 160 ++++++++++++++++
 tb/tb_ctrl_fsm_v2.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm_v2.sv
// ctrl_fsm_v2: instruction control FSM sequencing ALU, register file, instruction pointer, qclk and pulse strobe,
// with fproc/sync handshakes, wait-state timeout, halt and sticky error trapping.
module ctrl_fsm_v2 #(
    parameter int OPCODE_W   = 8,
    parameter int ALU_OP_W   = 3,
    parameter int TIMEOUT_W  = 16,
    parameter int TIMEOUT_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 cstrobe_in,
    input  logic                 fproc_valid,
    input  logic                 sync_enable,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic [ALU_OP_W-1:0]  alu_opcode,
    output logic                 alu_in0_sel,
    output logic [1:0]           alu_in1_sel,
    output logic                 c_strobe_enable,
    output logic                 reg_write_en,
    output logic                 instr_ptr_en,
    output logic [1:0]           instr_ptr_load_en,
    output logic                 qclk_load_en,
    output logic                 fproc_out_ready,
    output logic                 sync_out_ready,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           state_out
);
    localparam int CW = OPCODE_W - ALU_OP_W;
    localparam logic [CW-1:0] C_PULSE_I     = CW'(5'b00001);
    localparam logic [CW-1:0] C_REG_I_ALU   = CW'(5'b00010);
    localparam logic [CW-1:0] C_REG_ALU     = CW'(5'b00011);
    localparam logic [CW-1:0] C_JUMP_I      = CW'(5'b00100);
    localparam logic [CW-1:0] C_JUMP_COND_I = CW'(5'b00101);
    localparam logic [CW-1:0] C_JUMP_COND   = CW'(5'b00110);
    localparam logic [CW-1:0] C_INC_QCLK    = CW'(5'b01000);
    localparam logic [CW-1:0] C_INC_QCLK_I  = CW'(5'b01001);
    localparam logic [CW-1:0] C_SYNC        = CW'(5'b01010);
    localparam logic [CW-1:0] C_FPROC       = CW'(5'b01011);
    localparam logic [CW-1:0] C_DONE        = CW'(5'b01100);
    localparam logic [2:0] S_INIT       = 3'd0;
    localparam logic [2:0] S_ALU_PROC   = 3'd1;
    localparam logic [2:0] S_JUMP_COND  = 3'd2;
    localparam logic [2:0] S_INC_QCLK   = 3'd3;
    localparam logic [2:0] S_FPROC_WAIT = 3'd4;
    localparam logic [2:0] S_SYNC_WAIT  = 3'd5;
    localparam logic [2:0] S_HALT       = 3'd6;
    localparam logic [2:0] S_ERR        = 3'd7;

    logic [2:0]           state, nxt;
    logic [TIMEOUT_W-1:0] cnt;
    logic [CW-1:0]        cls;
    logic                 waiting, timed_out;

    assign cls        = opcode[OPCODE_W-1:ALU_OP_W];
    assign alu_opcode = opcode[ALU_OP_W-1:0];
    assign state_out  = state;
    assign done       = state == S_HALT;
    assign err        = state == S_ERR;
    assign waiting    = state == S_FPROC_WAIT || state == S_SYNC_WAIT;
    // cnt holds the number of wait cycles already elapsed, so the limit is hit on the cycle it would reach it
    assign timed_out  = TIMEOUT_EN != 0 && |timeout_limit &&
                        ({1'b0, cnt} + (TIMEOUT_W+1)'(1)) >= {1'b0, timeout_limit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= waiting ? (&cnt ? cnt : cnt + TIMEOUT_W'(1)) : '0;
        end
    end

    always_comb begin
        nxt               = state;
        alu_in0_sel       = 1'b0;
        alu_in1_sel       = 2'd0;
        c_strobe_enable   = 1'b0;
        reg_write_en      = 1'b0;
        instr_ptr_en      = 1'b0;
        instr_ptr_load_en = 2'd0;
        qclk_load_en      = 1'b0;
        fproc_out_ready   = 1'b0;
        sync_out_ready    = 1'b0;
        case (state)
            S_INIT: begin
                case (cls)
                    C_PULSE_I: begin
                        c_strobe_enable = 1'b1;
                        instr_ptr_en    = cstrobe_in;
                    end
                    C_REG_I_ALU: nxt = S_ALU_PROC;
                    C_REG_ALU: begin
                        nxt         = S_ALU_PROC;
                        alu_in0_sel = 1'b1;
                    end
                    C_JUMP_I: begin
                        instr_ptr_en      = 1'b1;
                        instr_ptr_load_en = 2'd1;
                    end
                    C_JUMP_COND_I: nxt = S_JUMP_COND;
                    C_JUMP_COND: begin
                        nxt         = S_JUMP_COND;
                        alu_in0_sel = 1'b1;
                    end
                    C_INC_QCLK: begin
                        nxt         = S_INC_QCLK;
                        alu_in0_sel = 1'b1;
                        alu_in1_sel = 2'd1;
                    end
                    C_INC_QCLK_I: begin
                        nxt         = S_INC_QCLK;
                        alu_in1_sel = 2'd1;
                    end
                    C_SYNC: begin
                        nxt            = S_SYNC_WAIT;
                        sync_out_ready = 1'b1;
                    end
                    C_FPROC: begin
                        nxt             = S_FPROC_WAIT;
                        fproc_out_ready = 1'b1;
                    end
                    C_DONE: nxt = S_HALT;
                    default: nxt = S_ERR;
                endcase
            end
            S_ALU_PROC: begin
                reg_write_en = 1'b1;
                instr_ptr_en = 1'b1;
                nxt          = S_INIT;
            end
            S_JUMP_COND: begin
                instr_ptr_en      = 1'b1;
                instr_ptr_load_en = 2'd2;
                nxt               = S_INIT;
            end
            S_INC_QCLK: begin
                qclk_load_en = 1'b1;
                instr_ptr_en = 1'b1;
                nxt          = S_INIT;
            end
            S_FPROC_WAIT: begin
                fproc_out_ready = 1'b1;
                alu_in0_sel     = 1'b1;
                alu_in1_sel     = 2'd2;
                reg_write_en    = fproc_valid;
                instr_ptr_en    = fproc_valid;
                nxt             = fproc_valid ? S_INIT : timed_out ? S_ERR : S_FPROC_WAIT;
            end
            S_SYNC_WAIT: begin
                sync_out_ready = 1'b1;
                instr_ptr_en   = sync_enable;
                nxt            = sync_enable ? S_INIT : timed_out ? S_ERR : S_SYNC_WAIT;
            end
            default: nxt = state;
        endcase
    end
endmodule

// File: tb/tb_ctrl_fsm_v2.sv
// tb_ctrl_fsm_v2: directed and random instruction sequences checked against a per-instruction cycle model.
module tb_ctrl_fsm_v2;
    localparam int K_PULSE = 1, K_REGI = 2, K_REG = 3, K_JMPI = 4, K_JCI = 5, K_JC = 6;
    localparam int K_INCQ = 8, K_INCQI = 9, K_SYNC = 10, K_FPROC = 11, K_DONE = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  opcode = '0;
    logic        cstrobe_in = 1'b0, fproc_valid = 1'b0, sync_enable = 1'b0;
    logic [15:0] timeout_limit = '0;
    logic [2:0]  alu_opcode, state_out;
    logic [1:0]  alu_in1_sel, instr_ptr_load_en;
    logic        alu_in0_sel, c_strobe_enable, reg_write_en, instr_ptr_en;
    logic        qclk_load_en, fproc_out_ready, sync_out_ready, done, err;
    logic [18:0] obs_v;
    int          total = 0, bad = 0;

    ctrl_fsm_v2 dut (
        .clk(clk), .reset(reset), .opcode(opcode), .cstrobe_in(cstrobe_in),
        .fproc_valid(fproc_valid), .sync_enable(sync_enable), .timeout_limit(timeout_limit),
        .alu_opcode(alu_opcode), .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel),
        .c_strobe_enable(c_strobe_enable), .reg_write_en(reg_write_en), .instr_ptr_en(instr_ptr_en),
        .instr_ptr_load_en(instr_ptr_load_en), .qclk_load_en(qclk_load_en),
        .fproc_out_ready(fproc_out_ready), .sync_out_ready(sync_out_ready),
        .done(done), .err(err), .state_out(state_out)
    );

    always #5 clk = ~clk;

    assign obs_v = {alu_opcode, alu_in0_sel, alu_in1_sel, c_strobe_enable, reg_write_en, instr_ptr_en,
                    instr_ptr_load_en, qclk_load_en, fproc_out_ready, sync_out_ready, done, err, state_out};

    function automatic logic [18:0] pk(input logic [2:0] a, input int i0, input int i1, input int cse,
                                       input int rwe, input int ipe, input int ipl, input int qle,
                                       input int fr, input int sr, input int dn, input int er, input int st);
        return {a, 1'(i0), 2'(i1), 1'(cse), 1'(rwe), 1'(ipe), 2'(ipl), 1'(qle),
                1'(fr), 1'(sr), 1'(dn), 1'(er), 3'(st)};
    endfunction

    // expected outputs for cycle c of one instruction; fin marks the completing (responded) cycle
    function automatic logic [18:0] model(input int k, input logic [2:0] a, input int c, input int fin);
        case (k)
            K_PULSE:        return pk(a, 0, 0, 1, 0, fin, 0, 0, 0, 0, 0, 0, 0);
            K_REGI, K_REG:  return c == 0 ? pk(a, int'(k == K_REG), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)
                                          : pk(a, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
            K_JMPI:         return pk(a, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
            K_JCI, K_JC:    return c == 0 ? pk(a, int'(k == K_JC), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)
                                          : pk(a, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 2);
            K_INCQ, K_INCQI: return c == 0 ? pk(a, int'(k == K_INCQ), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)
                                           : pk(a, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 3);
            K_FPROC:        return c == 0 ? pk(a, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)
                                          : pk(a, 1, 2, 0, fin, fin, 0, 0, 1, 0, 0, 0, 4);
            K_SYNC:         return c == 0 ? pk(a, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)
                                          : pk(a, 0, 0, 0, 0, fin, 0, 0, 0, 1, 0, 0, 5);
            default:        return pk(a, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic bit legal(input int k);
        return k inside {K_PULSE, K_REGI, K_REG, K_JMPI, K_JCI, K_JC, K_INCQ, K_INCQI, K_SYNC, K_FPROC, K_DONE};
    endfunction

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        opcode = '0;
        cstrobe_in = 1'b0;
        fproc_valid = 1'b0;
        sync_enable = 1'b0;
        step();
        #3 chk("reset", obs_v, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
    endtask

    // run one instruction: resp = strobe cycle (pulse) or first cycle the response is high (waits)
    task automatic exec(input int k, input int a, input int lim, input int resp);
        int kd, n, ends;
        bit wt, to, ilg;
        logic [2:0] al;
        logic [4:0] kc;
        al = a[2:0];
        kc = k[4:0];
        wt = k == K_SYNC || k == K_FPROC;
        kd = resp < 1 ? 1 : resp;
        ilg = !legal(k);
        to = wt && lim != 0 && lim < kd;
        n = k == K_PULSE ? resp + 1 : (k == K_JMPI || k == K_DONE || ilg) ? 1 : wt ? (to ? lim + 1 : kd + 1) : 2;
        reset = 1'b0;
        opcode = {kc, al};
        timeout_limit = 16'(lim);
        for (int c = 0; c < n; c++) begin
            cstrobe_in = k == K_PULSE && c == resp;
            fproc_valid = k == K_FPROC && c >= resp;
            sync_enable = k == K_SYNC && c >= resp;
            #3 chk($sformatf("op%0d_lim%0d_resp%0d_cyc%0d", k, lim, resp, c), obs_v,
                   model(k, al, c, int'(c == n - 1 && !to)));
            step();
        end
        if (to || ilg || k == K_DONE) begin
            ends = k == K_DONE ? 20 : 3;
            for (int c = 0; c < ends; c++) begin
                cstrobe_in = 1'($urandom);
                fproc_valid = 1'($urandom);
                sync_enable = 1'($urandom);
                #3 chk($sformatf("op%0d_absorb%0d", k, c), obs_v,
                       pk(al, 0, 0, 0, 0, 0, 0, 0, 0, 0, int'(k == K_DONE), int'(k != K_DONE),
                          k == K_DONE ? 6 : 7));
                step();
            end
            do_reset();
        end
    endtask

    initial begin
        int pool [13] = '{1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 31, 7};
        do_reset();
        exec(K_REG, 1, 0, 0);
        exec(K_REGI, 5, 0, 0);
        exec(K_PULSE, 2, 0, 5);
        exec(K_JMPI, 3, 0, 0);
        exec(K_JCI, 4, 0, 0);
        exec(K_JC, 6, 0, 0);
        exec(K_INCQ, 7, 0, 0);
        exec(K_INCQI, 0, 0, 0);
        exec(K_FPROC, 2, 0, 7);
        exec(K_FPROC, 1, 4, 0);
        exec(K_SYNC, 0, 10, 1000);
        exec(K_SYNC, 0, 10, 10);
        exec(K_SYNC, 3, 1, 1);
        exec(K_FPROC, 3, 1, 2);
        exec(31, 0, 0, 0);
        exec(K_DONE, 5, 0, 0);
        reset = 1'b0;
        opcode = {5'd11, 3'd2};
        timeout_limit = 16'd0;
        fproc_valid = 1'b0;
        step();
        step();
        step();
        #3 chk("mid_fproc_wait", obs_v, pk(2, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4));
        reset = 1'b1;
        opcode = '0;
        step();
        #3 chk("mid_fproc_reset", obs_v, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        exec(K_SYNC, 1, 3, 50);
        for (int i = 0; i < 60; i++)
            exec(pool[$urandom_range(0, 12)], int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 8)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
